key_debounce8: RTL and testbench

Upstream conditioning stage for the 8-to-3 encoder. Takes 8 raw, bouncing, active-low key lines, synchronises them to clk and debounces each one. Drives a clean active-low 8-bit vector straight into the encoder's I input. Also produces per-key press strobes and status flags for downstream capture logic.

---
 rtl/key_debounce8_pkg.sv | 18 +
 rtl/key_debounce8_db_cell.sv | 68 ++++++
 rtl/key_debounce8.sv | 57 +++++
 tb/tb_key_debounce8.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/key_debounce8_pkg.sv
// key_pkg: shared constants and helpers for the key_debounce8 conditioning stage.
//   N_KEYS            number of key lines handled
//   KEY_IDLE          active-low vector with no key pressed (reset value)
//   KEY_UP            single-bit released level
//   DB_CYCLES_DEFAULT default debounce length in clk cycles
package key_pkg;

    localparam int                N_KEYS            = 8;
    localparam logic [N_KEYS-1:0] KEY_IDLE          = 8'hFF;
    localparam logic              KEY_UP            = 1'b1;
    localparam int                DB_CYCLES_DEFAULT = 50000;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [N_KEYS-1:0] v);
        return (v != '0) && ((v & (v - N_KEYS'(1))) == '0);
    endfunction

endpackage

// File: rtl/key_debounce8_db_cell.sv
// db_cell: one key line's 2-flop synchroniser, debounce counter, stable level
// flop and press (1->0) strobe.
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   en          block enable; when low the counter is held at 0
//   hold_i      lockout request; holds the counter at 0 like en=0
//   key_n_i     raw asynchronous key line, active-low
//   key_db_n_o  debounced level, active-low
//   press_o     one-cycle strobe coinciding with a new debounced 0
module db_cell
    import key_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic hold_i,
    input  logic key_n_i,
    output logic key_db_n_o,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronised level disagrees with the
    // accepted level; any agreement (glitch over) clears it.
    always_comb begin
        stable_d = stable_q;
        press_d  = 1'b0;
        cnt_d    = '0;
        if (en && !hold_i && (sync2_q != stable_q)) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                press_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= KEY_UP;
            sync2_q  <= KEY_UP;
            stable_q <= KEY_UP;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= key_n_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign key_db_n_o = stable_q;
    assign press_o    = press_q;

endmodule

// File: rtl/key_debounce8.sv
// key_debounce8: synchronises and debounces 8 active-low key lines feeding the
// 8-to-3 encoder's I input, with per-key press strobes and status flags.
// Ports:
//   clk             system clock
//   rst             synchronous active-high reset
//   en              block enable (encoder E)
//   key_n[7:0]      raw key lines, active-low
//   key_db_n[7:0]   debounced key vector, active-low
//   press_pulse[7:0] one-cycle strobe per key on debounced press
//   any_pressed     some key_db_n bit is 0
//   single_pressed  exactly one key_db_n bit is 0
// Build option: define KEY_LOCKOUT_EN to stop released keys from being
// accepted while any key is held down.
module key_debounce8
    import key_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_db_n,
    output logic [N_KEYS-1:0] press_pulse,
    output logic              any_pressed,
    output logic              single_pressed
);

    logic [N_KEYS-1:0] hold;

`ifdef KEY_LOCKOUT_EN
    // Only released keys are held; held keys can still debounce their release.
    assign hold = {N_KEYS{any_pressed}} & key_db_n;
`else
    assign hold = '0;
`endif

    for (genvar i = 0; i < N_KEYS; i++) begin : g_cell
        db_cell #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .hold_i     (hold[i]),
            .key_n_i    (key_n[i]),
            .key_db_n_o (key_db_n[i]),
            .press_o    (press_pulse[i])
        );
    end

    assign any_pressed    = (key_db_n != KEY_IDLE);
    assign single_pressed = is_onehot(~key_db_n);

endmodule

// File: tb/tb_key_debounce8.sv
// Testbench for key_debounce8 (DB_CYCLES=4): directed scenarios plus random
// stimulus, checked every cycle against a sliding-window reference model.
module tb_key_debounce8;

    localparam int DB  = 4;
    localparam int CW  = 4;
    localparam int MAXE = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [7:0] key_n = 8'h00;
    logic [7:0] key_db_n, press_pulse;
    logic       any_pressed, single_pressed;

    int checks = 0;
    int errors = 0;

    key_debounce8 #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .key_n          (key_n),
        .key_db_n       (key_db_n),
        .press_pulse    (press_pulse),
        .any_pressed    (any_pressed),
        .single_pressed (single_pressed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] db;
        logic [7:0] pulse;
        logic       any;
        logic       single;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: a key level is accepted when the last DB edges (with no
    // earlier acceptance among them) all saw an enabled, differing sample.
    logic [7:0] elig_h [MAXE];
    logic [7:0] upd_h  [MAXE];
    logic [7:0] m_s1 = 8'hFF, m_s2 = 8'hFF, m_stable = 8'hFF, m_pulse = 8'h00;

    initial begin : model
        int         k;
        logic [7:0] cmp, upd;
        logic       anyp, ok;
        k = 0;
        forever begin
            @(posedge clk);
            if (k < MAXE) begin
                if (rst) begin
                    m_s1 = 8'hFF; m_s2 = 8'hFF; m_stable = 8'hFF; m_pulse = 8'h00;
                    elig_h[k] = 8'h00; upd_h[k] = 8'h00;
                end else begin
                    cmp  = m_s2;
                    anyp = (m_stable != 8'hFF);
                    for (int i = 0; i < 8; i++) begin
                        ok = en && (cmp[i] != m_stable[i]);
`ifdef KEY_LOCKOUT_EN
                        if (anyp && m_stable[i]) ok = 1'b0;
`endif
                        elig_h[k][i] = ok;
                    end
                    upd = 8'h00;
                    for (int i = 0; i < 8; i++) begin
                        ok = 1'b1;
                        for (int d = 0; d < DB; d++) begin
                            if (k - d < 0) ok = 1'b0;
                            else if (!elig_h[k-d][i]) ok = 1'b0;
                            else if (d > 0 && upd_h[k-d][i]) ok = 1'b0;
                        end
                        upd[i] = ok;
                    end
                    upd_h[k] = upd;
                    m_pulse  = upd & ~cmp;
                    m_stable = (m_stable & ~upd) | (cmp & upd);
                    m_s2 = m_s1;
                    m_s1 = key_n;
                end
                sb_q.push_back('{db: m_stable, pulse: m_pulse,
                                 any: (m_stable != 8'hFF),
                                 single: ($countones(~m_stable) == 1)});
                k++;
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("key_db_n", key_db_n, e.db);
                chk("press_pulse", press_pulse, e.pulse);
                chk("any_pressed", {7'b0, any_pressed}, {7'b0, e.any});
                chk("single_pressed", {7'b0, single_pressed}, {7'b0, e.single});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Counts edges until key_db_n reaches tgt (bounded) and checks the count.
    task automatic wait_lat(input logic [7:0] tgt, input int exp, input string nm);
        int n;
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            #2;
            n++;
            if (key_db_n == tgt) break;
        end
        checks++;
        if (n != exp) begin
            errors++;
            $display("FAIL %s: latency %0d cycles, expected %0d", nm, n, exp);
        end
    endtask

    initial begin : stim
        int r;
        // 1: reset dominates pressed keys, then 8'h00 accepted 6 cycles later
        rst = 1'b1; en = 1'b1; key_n = 8'h00;
        step(3);
        rst = 1'b0;
        wait_lat(8'h00, 6, "reset_release_accept");
        key_n = 8'hFF;
        wait_lat(8'hFF, 6, "release_all");
        // 2: single clean press
        key_n = 8'hFE;
        wait_lat(8'hFE, 6, "press_bit0");
        key_n = 8'hFF;
        wait_lat(8'hFF, 6, "release_bit0");
        // 3: bounce on bit 3
        key_n = 8'hF7; step(2);
        key_n = 8'hFF; step(1);
        key_n = 8'hF7;
        wait_lat(8'hF7, 6, "bounce_bit3");
        // 4: release
        key_n = 8'hFF;
        wait_lat(8'hFF, 6, "release_bit3");
        // 5: two keys together, then staggered
        key_n = 8'h7E;
        wait_lat(8'h7E, 6, "two_keys");
        key_n = 8'hFF;
        wait_lat(8'hFF, 6, "two_keys_release");
        key_n = 8'hFE; step(3);
        key_n = 8'h7E; step(15);
        key_n = 8'hFF; step(12);
        // 6: enable dropped mid-count on bit 5
        key_n = 8'hDF; step(4);
        en = 1'b0; step(6);
        en = 1'b1;
        wait_lat(8'hDF, 4, "en_restart");
        key_n = 8'hFF;
        wait_lat(8'hFF, 6, "release_bit5");
        // random phase
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 19);
            if (r < 9)       key_n = key_n ^ (8'h01 << $urandom_range(0, 7));
            else if (r < 12) key_n = 8'($urandom);
            else if (r < 14) key_n = 8'hFF;
            else if (r < 17) en = ~en;
            else if (r == 17) begin
                rst = 1'b1; step(1); rst = 1'b0;
            end
            else en = 1'b1;
            step($urandom_range(1, 10));
        end
        en = 1'b1;
        step(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
